// File: rtl/fpu_add_round.sv
// Rounds the adder's 35-bit unrounded sum to binary32 and holds the result and flags until the consumer accepts them.
// The result appears 2 cycles after start plus any cycles the adder stays busy, and is held stable while res_ready is low.
module fpu_add_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  rm,
    input  logic        add_busy,
    input  logic [34:0] add_out,
    input  logic        res_ready,
    input  logic        flags_clr,
    output logic        res_valid,
    output logic [31:0] res,
    output logic [4:0]  fflags,
    output logic [4:0]  fflags_acc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  rm_q, rm_d;
    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [4:0]  acc_q, acc_d;

    logic        sign;
    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic        g_bit, r_bit, s_bit;
    logic        nx;
    logic        inc;
    logic [30:0] sum;
    logic [31:0] rnd_res;
    logic [4:0]  rnd_flags;
    logic        accept;
    logic        start_ok;

    assign sign    = add_out[34];
    assign exp_in  = add_out[33:26];
    assign frac_in = add_out[25:3];
    assign g_bit   = add_out[2];
    assign r_bit   = add_out[1];
    assign s_bit   = add_out[0];
    assign nx      = g_bit | r_bit | s_bit;

    always_comb begin
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign & nx;
            3'b011:  inc = ~sign & nx;
            3'b100:  inc = g_bit;
            default: inc = g_bit & (r_bit | s_bit | frac_in[0]);
        endcase
    end

    // Incrementing {exp, frac} as one field lets mantissa carry roll into the exponent.
    assign sum = {exp_in, frac_in} + {30'd0, inc};

    always_comb begin
        rnd_res   = {sign, sum};
        rnd_flags = {3'b000, (sum[30:23] == 8'h00) & nx, nx};
        if (exp_in == 8'hFF) begin
            if (frac_in != 23'd0) begin
                // 23'h400001 is the adder's quiet-looking marker for inf - inf.
                rnd_res   = 32'h7FC0_0000;
                rnd_flags = {~frac_in[22] | (frac_in == 23'h400001), 4'b0000};
            end else begin
                rnd_res   = {sign, 8'hFF, 23'd0};
                rnd_flags = 5'b00000;
            end
        end else if (sum[30:23] == 8'hFF) begin
            rnd_res   = {sign, 8'hFF, 23'd0};
            rnd_flags = 5'b00101;
        end
    end

    assign accept   = valid_q & res_ready;
    assign start_ok = start & ((state_q == S_IDLE) | ((state_q == S_DONE) & res_ready));

    always_comb begin
        state_d  = state_q;
        rm_d     = rm_q;
        valid_d  = valid_q;
        res_d    = res_q;
        fflags_d = fflags_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!add_busy) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    res_d    = rnd_res;
                    fflags_d = rnd_flags;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = start ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start_ok) rm_d = rm;
        if (flags_clr) begin
            acc_d = accept ? fflags_q : 5'b00000;
        end else if (accept) begin
            acc_d = acc_q | fflags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rm_q     <= 3'b000;
            valid_q  <= 1'b0;
            res_q    <= 32'd0;
            fflags_q <= 5'd0;
            acc_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            rm_q     <= rm_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            fflags_q <= fflags_d;
            acc_q    <= acc_d;
        end
    end

    assign res_valid  = valid_q;
    assign res        = res_q;
    assign fflags     = fflags_q;
    assign fflags_acc = acc_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_add_round.sv
// Table-driven bench for fpu_add_round with a scoreboard of expected results and accumulated-flag model.
module tb_fpu_add_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  rm;
    logic        add_busy;
    logic [34:0] add_out;
    logic        res_ready;
    logic        flags_clr;
    logic        res_valid;
    logic [31:0] res;
    logic [4:0]  fflags;
    logic [4:0]  fflags_acc;
    logic        busy;

    fpu_add_round dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rm         (rm),
        .add_busy   (add_busy),
        .add_out    (add_out),
        .res_ready  (res_ready),
        .flags_clr  (flags_clr),
        .res_valid  (res_valid),
        .res        (res),
        .fflags     (fflags),
        .fflags_acc (fflags_acc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m;
        logic [34:0] ao;
        logic [31:0] er;
        logic [4:0]  ef;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] er;
        logic [4:0]  ef;
    } exp_t;

    localparam int NVEC = 23;

    vec_t       vecs [NVEC];
    exp_t       sb [$];
    exp_t       mon_e;
    int         tests = 0;
    int         fails = 0;
    logic [4:0] acc_model = 5'd0;

    function automatic logic [34:0] mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                                       input logic [2:0] grs);
        return {s, e, f, grs};
    endfunction

    function automatic logic [34:0] junk();
        return {3'($urandom_range(7, 0)), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Scoreboard and fflags_acc model, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            acc_model = 5'd0;
        end else begin
            chk("fflags_acc", 32'(fflags_acc), 32'(acc_model));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("res[%0d]", mon_e.id), res, mon_e.er);
                    chk($sformatf("fflags[%0d]", mon_e.id), 32'(fflags), 32'(mon_e.ef));
                    acc_model = flags_clr ? mon_e.ef : (acc_model | mon_e.ef);
                end
            end else if (flags_clr) begin
                acc_model = 5'd0;
            end
        end
    end

    task automatic do_op(input int id, input vec_t v, input int nb, input bit clr);
        exp_t e;
        @(posedge clk); #1;
        start    = 1'b1;
        rm       = v.m;
        add_busy = 1'b1;
        add_out  = junk();
        e.id = id; e.er = v.er; e.ef = v.ef;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        rm    = 3'($urandom_range(7, 0));
        chk($sformatf("wait_state[%0d]", id), 32'({res_valid, busy}), 32'b01);
        for (int i = 0; i < nb; i++) begin
            add_busy = 1'b1;
            add_out  = junk();
            @(posedge clk); #1;
            chk($sformatf("still_waiting[%0d]", id), 32'(res_valid), 32'd0);
        end
        add_busy = 1'b0;
        add_out  = v.ao;
        @(posedge clk); #1;
        chk($sformatf("latency[%0d]", id), 32'(res_valid), 32'd1);
        add_busy  = 1'b1;
        add_out   = junk();
        res_ready = 1'b1;
        flags_clr = clr;
        @(posedge clk); #1;
        res_ready = 1'b0;
        flags_clr = 1'b0;
        chk($sformatf("idle_after_accept[%0d]", id), 32'({res_valid, busy}), 32'd0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'd0, mk(1'b0, 8'h7F, 23'h000001, 3'b100), 32'h3F800002, 5'b00001};
        vecs[1]  = '{3'd0, mk(1'b0, 8'h7F, 23'h000000, 3'b100), 32'h3F800000, 5'b00001};
        vecs[2]  = '{3'd0, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b110), 32'h7F800000, 5'b00101};
        vecs[3]  = '{3'd1, mk(1'b0, 8'hFE, 23'h7FFFFF, 3'b110), 32'h7F7FFFFF, 5'b00001};
        vecs[4]  = '{3'd2, mk(1'b1, 8'h80, 23'h000000, 3'b001), 32'hC0000001, 5'b00001};
        vecs[5]  = '{3'd3, mk(1'b1, 8'h80, 23'h000000, 3'b001), 32'hC0000000, 5'b00001};
        vecs[6]  = '{3'd0, mk(1'b0, 8'h00, 23'h000001, 3'b100), 32'h00000002, 5'b00011};
        vecs[7]  = '{3'd0, mk(1'b0, 8'hFF, 23'h400001, 3'b000), 32'h7FC00000, 5'b10000};
        vecs[8]  = '{3'd0, mk(1'b0, 8'hFF, 23'h400000, 3'b000), 32'h7FC00000, 5'b00000};
        vecs[9]  = '{3'd0, mk(1'b1, 8'hFF, 23'h000001, 3'b000), 32'h7FC00000, 5'b10000};
        vecs[10] = '{3'd0, mk(1'b1, 8'hFF, 23'h000000, 3'b000), 32'hFF800000, 5'b00000};
        vecs[11] = '{3'd2, mk(1'b1, 8'h00, 23'h000000, 3'b000), 32'h80000000, 5'b00000};
        vecs[12] = '{3'd0, mk(1'b0, 8'h7F, 23'h7FFFFF, 3'b100), 32'h40000000, 5'b00001};
        vecs[13] = '{3'd0, mk(1'b0, 8'h00, 23'h7FFFFF, 3'b110), 32'h00800000, 5'b00001};
        vecs[14] = '{3'd4, mk(1'b0, 8'h7F, 23'h000000, 3'b100), 32'h3F800001, 5'b00001};
        vecs[15] = '{3'd6, mk(1'b0, 8'h7F, 23'h000000, 3'b100), 32'h3F800000, 5'b00001};
        vecs[16] = '{3'd3, mk(1'b0, 8'h7F, 23'h000000, 3'b001), 32'h3F800001, 5'b00001};
        vecs[17] = '{3'd0, mk(1'b0, 8'h7F, 23'h000000, 3'b110), 32'h3F800001, 5'b00001};
        vecs[18] = '{3'd0, mk(1'b1, 8'hFE, 23'h7FFFFF, 3'b100), 32'hFF800000, 5'b00101};
        vecs[19] = '{3'd3, mk(1'b1, 8'hFE, 23'h7FFFFF, 3'b001), 32'hFF7FFFFF, 5'b00001};
        vecs[20] = '{3'd2, mk(1'b0, 8'h00, 23'h000000, 3'b010), 32'h00000000, 5'b00011};
        vecs[21] = '{3'd3, mk(1'b0, 8'h00, 23'h000000, 3'b010), 32'h00000001, 5'b00011};
        vecs[22] = '{3'd0, mk(1'b0, 8'h03, 23'h123456, 3'b000), 32'h01923456, 5'b00000};

        rst = 1'b1; start = 1'b0; rm = 3'd0; add_busy = 1'b0; add_out = '0;
        res_ready = 1'b0; flags_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({res_valid, busy, fflags, fflags_acc}), 32'd0);
        chk("reset_res", res, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            do_op(i, vecs[i], i % 3, 1'b0);
        end

        // Accumulated flags: clear, NaN sets NV, clear again, then clear coinciding with accept.
        pulse_clr();
        chk("acc_cleared", 32'(fflags_acc), 32'd0);
        do_op(100, vecs[7], 0, 1'b0);
        chk("acc_nv", 32'(fflags_acc), 32'b10000);
        pulse_clr();
        chk("acc_cleared2", 32'(fflags_acc), 32'd0);
        do_op(101, vecs[2], 1, 1'b0);
        chk("acc_of", 32'(fflags_acc), 32'b00101);
        do_op(102, vecs[0], 0, 1'b1);
        chk("acc_clr_with_accept", 32'(fflags_acc), 32'b00001);

        // Hold in DONE with start pulses, then accept plus back-to-back start.
        @(posedge clk); #1;
        start = 1'b1; rm = 3'd0; add_busy = 1'b1; add_out = junk();
        sb.push_back('{200, 32'h3F800002, 5'b00001});
        @(posedge clk); #1;
        start = 1'b0; add_busy = 1'b0; add_out = vecs[0].ao;
        @(posedge clk); #1;
        add_busy = 1'b1; add_out = junk();
        chk("hold_valid_rise", 32'(res_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; rm = 3'd3;
            @(posedge clk); #1;
            chk("hold_res", res, 32'h3F800002);
            chk("hold_flags_valid_busy", 32'({fflags, res_valid, busy}), 32'b0000111);
        end
        res_ready = 1'b1; start = 1'b1; rm = 3'd1;
        sb.push_back('{201, 32'h7F7FFFFF, 5'b00001});
        @(posedge clk); #1;
        res_ready = 1'b0; start = 1'b0; rm = 3'd0;
        chk("b2b_wait", 32'({res_valid, busy}), 32'b01);
        add_busy = 1'b0; add_out = vecs[3].ao;
        @(posedge clk); #1;
        add_busy = 1'b1; add_out = junk();
        chk("b2b_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Long adder busy period.
        do_op(300, vecs[12], 5, 1'b0);

        // Reset between edges while in WAIT, then a normal operation.
        @(posedge clk); #1;
        start = 1'b1; rm = 3'd0; add_busy = 1'b1; add_out = junk();
        @(posedge clk); #1;
        start = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({res_valid, busy, fflags, fflags_acc}), 32'd0);
        chk("async_reset_res", res, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        add_busy = 1'b0;
        do_op(400, vecs[4], 1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_add_round.md
# fpu_add_round

Rounding and result-capture stage directly downstream of the floating-point adder in the EX-stage FPU. It launches alongside each adder operation and waits on the adder's busy flag until normalisation completes. It then rounds the adder's 35-bit unrounded result ({sign, exp[7:0], frac[22:0], G, R, S}) to IEEE-754 binary32 in the selected rounding mode. It holds the result and exception flags under a valid/ready handshake until the writeback side accepts them.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  operation launched; same cycle as the adder's new_input pulse.
- rm  in  3  rounding mode, sampled on accepted start: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, 101–111 treated as RNE.
- add_busy  in  1  adder busy flag.
- add_out  in  35  adder unrounded result.
- res_ready  in  1  consumer accepts result.
- res_valid  out  1  result and fflags valid.
- res  out  32  rounded binary32 result.
- fflags  out  5  {NV, DZ, OF, UF, NX} for res; DZ is always 0.
- fflags_acc  out  5  sticky OR of fflags over all accepted results.
- flags_clr  in  1  clears fflags_acc.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: accepted start → WAIT; rm is latched.
  - WAIT: first cycle with add_busy=0 → sample add_out, round, register res/fflags → DONE.
  - DONE: res_valid=1; res_ready=1 → IDLE, unless start is also high that cycle, which goes → WAIT (back-to-back).
- start is accepted only in IDLE, or in DONE with res_ready=1. Any other start is ignored, with no state change.
- Special inputs, checked first:
  - exp=FF with frac≠0: res=0x7FC00000 (canonical NaN).
    - NV=1 if frac[22]=0 (sNaN) or frac=23'h400001 (adder's inf−inf marker); otherwise NV=0.
    - No other flags.
  - exp=FF with frac=0: pass through as ±inf, flags 0.
- Rounding on the remaining inputs:
  - Definitions: lsb=frac[0]; NX=G|R|S.
  - Increment rule per mode:
    - RNE: G&(R|S|lsb).
    - RTZ: 0.
    - RDN: sign&NX.
    - RUP: ~sign&NX.
    - RMM: G.
  - The 31-bit {exp, frac} is incremented; carries ripple from frac into exp (1.111…→2.0, subnormal→min normal).
  - OF: post-increment exp=FF. Sets OF|NX; res=±inf (frac 0).
  - UF: post-rounding exp=0 and NX=1. Sets UF|NX (tininess detected after rounding).
  - Exact zero input: passes through unchanged, including its sign.
- fflags_acc ORs in fflags on the DONE→accept handshake. If flags_clr coincides with an accept, the result is exactly that result's fflags. flags_clr alone → 0.

## Timing
- Reset values: res_valid 0, res 0, fflags 0, fflags_acc 0, busy 0, state IDLE, latched rm 000.
- Reset is honoured asynchronously in any state; an in-flight operation is discarded.
  - Reset must span at least one clk edge so the synchronous-reset adder also clears.
- Latency: start at cycle T; WAIT from T+1.
  - If add_busy=0 at T+1+n, res_valid rises at T+2+n.
  - Minimum latency is 2 cycles (special cases and already-normalised sums).
- res, fflags and res_valid are registered outputs. res/fflags are stable while res_valid=1 and res_ready=0.
- Back-to-back: accept plus start in the same cycle gives WAIT next cycle, so res_valid drops for at least one cycle.
- add_out is sampled only in WAIT with add_busy=0 and is ignored otherwise.

## Test plan
- RNE ties:
  - add_out {0,7F,000001,100} → res 0x3F800002, fflags 00001.
  - add_out {0,7F,000000,100} → res 0x3F800000, fflags 00001.
- Overflow:
  - {0,FE,7FFFFF,110}, RNE → 0x7F800000, fflags 00101.
  - Same input, RTZ → 0x7F7FFFFF, fflags 00001.
- Directed modes and underflow:
  - {1,80,000000,001}, RDN → 0xC0000001, NX.
  - Same input, RUP → 0xC0000000, NX.
  - {0,00,000001,100}, RNE → 0x00000002, fflags 00011.
- NaN: add_out {0,9'h1FF,22'h1,000} → 0x7FC00000, fflags 10000; fflags_acc=10000 after accept; flags_clr → 00000.
- Handshake:
  - Hold res_ready=0 for 3 cycles in DONE with start pulsed → res stable, start ignored, busy=1.
  - Then res_ready=1 with start → next cycle WAIT; second result follows.
  - add_busy held high 5 cycles after start → res_valid exactly 1 cycle after add_busy falls.
- Reset asserted mid-WAIT between clock edges → outputs 0 immediately, IDLE; a subsequent start completes normally.
